// File: rtl/arb_burst_forwarder.sv
// ---------------------------------------------------------------------------
// arb_burst_forwarder
//
// Purpose:
//   Consumes the one-hot grant/vld pair from priority_arbiter and forwards the
//   granted requester's beat into a single registered output stage.
//   A burst is locked to its first requester until that requester presents
//   src_last. Grant changes are ignored during the burst, so bursts never
//   interleave.
//
// Handshake:
//   An output beat transfers on a cycle where out_valid && out_ready.
//   out_data, out_id and out_last hold stable while out_valid && !out_ready.
//   A source beat is accepted in a cycle exactly when its src_ack bit is high.
//   Acceptance needs the output slot to be free (empty or draining this cycle).
//
// Ports:
//   clk, resetn      clock and asynchronous active-low reset
//   grant, vld       one-hot grant and any-request flag from the arbiter
//   src_valid        per-requester beat valid
//   src_data         packed per-requester payloads, i at [i*DATA_W +: DATA_W]
//   src_last         per-requester end-of-burst flag
//   src_ack          one-hot accept pulse back to the requesters (combinational)
//   out_valid/ready  output channel handshake
//   out_data         output payload
//   out_id           out_data's source requester index
//   out_last         out_data's end-of-burst flag
//   busy             high while locked in a burst (debug view of the FSM)
//   onehot_err       sticky flag for a non-one-hot grant while vld is high
// ---------------------------------------------------------------------------
module arb_burst_forwarder #(
  parameter  int NUM_INPUTS = 4,
  parameter  int DATA_W     = 32,
  localparam int ID_W       = $clog2(NUM_INPUTS)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_INPUTS-1:0]        grant,
  input  logic                         vld,
  input  logic [NUM_INPUTS-1:0]        src_valid,
  input  logic [NUM_INPUTS*DATA_W-1:0] src_data,
  input  logic [NUM_INPUTS-1:0]        src_last,
  output logic [NUM_INPUTS-1:0]        src_ack,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [ID_W-1:0]              out_id,
  output logic                         out_last,
  output logic                         busy,
  output logic                         onehot_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [ID_W-1:0]     out_id_q;
  logic                out_last_q;
  logic                onehot_err_q;

  logic                slot_free;
  logic [ID_W-1:0]     sel;
  logic [ID_W:0]       grant_cnt;
  logic                bad_grant;
  logic                accept;
  logic [ID_W-1:0]     acc_idx;
  logic [DATA_W-1:0]   beat_data;
  logic                beat_last;

  assign slot_free = !out_valid_q || out_ready;

  // Grant decode: lowest set bit wins, so a malformed grant still picks
  // a deterministic source.
  always_comb begin
    sel       = '0;
    grant_cnt = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (grant[i]) sel = ID_W'(i);
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      grant_cnt = grant_cnt + (ID_W+1)'(grant[i]);
    end
    bad_grant = vld && (grant_cnt != (ID_W+1)'(1));
  end

  // FSM next state and accept decision.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    accept  = 1'b0;
    acc_idx = owner_q;
    case (state_q)
      IDLE: begin
        if (vld && slot_free) begin
          accept  = 1'b1;
          acc_idx = sel;
          if (!src_last[sel]) begin
            state_d = BURST;
            owner_d = sel;
          end
        end
      end
      BURST: begin
        // grant/vld are deliberately ignored here; only the owner can advance.
        if (src_valid[owner_q] && slot_free) begin
          accept = 1'b1;
          if (src_last[owner_q]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The ack is combinational, so it must be masked while reset is held.
    if (!resetn) accept = 1'b0;
  end

  // Source beat mux and ack decode.
  always_comb begin
    beat_data = '0;
    beat_last = 1'b0;
    src_ack   = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (acc_idx == ID_W'(i)) begin
        beat_data  = src_data[i*DATA_W +: DATA_W];
        beat_last  = src_last[i];
        src_ack[i] = accept;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= '0;
      out_last_q   <= 1'b0;
      onehot_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (accept) begin
        // A new beat loads even when the current one pops this same cycle.
        out_valid_q <= 1'b1;
        out_data_q  <= beat_data;
        out_id_q    <= acc_idx;
        out_last_q  <= beat_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (bad_grant) onehot_err_q <= 1'b1;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q == BURST);
  assign onehot_err = onehot_err_q;

endmodule

// File: tb/tb_arb_burst_forwarder.sv
// ---------------------------------------------------------------------------
// tb_arb_burst_forwarder
//
// Directed bench for arb_burst_forwarder (NUM_INPUTS=4, DATA_W=32).
// Inputs change at posedge+1. Combinational src_ack is checked one time unit
// after that. Registered outputs are checked right after the next posedge+1.
// ---------------------------------------------------------------------------
module tb_arb_burst_forwarder;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int IW   = 2;

  logic            clk;
  logic            resetn;
  logic [N-1:0]    grant;
  logic            vld;
  logic [N-1:0]    src_valid;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_last;
  logic [N-1:0]    src_ack;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;
  logic            out_last;
  logic            busy;
  logic            onehot_err;

  int tests_run;
  int tests_failed;

  arb_burst_forwarder #(.NUM_INPUTS(N), .DATA_W(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .grant      (grant),
    .vld        (vld),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_last   (src_last),
    .src_ack    (src_ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_last   (out_last),
    .busy       (busy),
    .onehot_err (onehot_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] v);
    src_data[idx*DW +: DW] = v;
  endtask

  task automatic clear_inputs();
    grant     = '0;
    vld       = 1'b0;
    src_valid = '0;
    src_last  = '0;
  endtask

  task automatic drive(input logic [N-1:0] g, input logic v,
                       input logic [N-1:0] sv, input logic [N-1:0] sl);
    grant     = g;
    vld       = v;
    src_valid = sv;
    src_last  = sl;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn    = 1'b0;
    out_ready = 1'b1;
    src_data  = '0;
    drive(4'b0001, 1'b1, 4'b0001, 4'b0001);
    #1;
    tests_run++; if (src_ack !== 4'b0000) begin tests_failed++; $display("FAIL reset_ack got=%b exp=0000", src_ack); end
    tick();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests_run++; if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    tests_run++; if (out_id !== 2'd0) begin tests_failed++; $display("FAIL reset_out_id got=%0d exp=0", out_id); end
    tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (onehot_err !== 1'b0) begin tests_failed++; $display("FAIL reset_onehot_err got=%b exp=0", onehot_err); end
    clear_inputs();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_beat();
    set_data(1, 32'hA5);
    drive(4'b0010, 1'b1, 4'b0010, 4'b0010);
    #1;
    tests_run++; if (src_ack !== 4'b0010) begin tests_failed++; $display("FAIL single_ack got=%b exp=0010", src_ack); end
    tick();
    clear_inputs();
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    tests_run++; if (out_data !== 32'hA5) begin tests_failed++; $display("FAIL single_out_data got=%h exp=a5", out_data); end
    tests_run++; if (out_id !== 2'd1) begin tests_failed++; $display("FAIL single_out_id got=%0d exp=1", out_id); end
    tests_run++; if (out_last !== 1'b1) begin tests_failed++; $display("FAIL single_out_last got=%b exp=1", out_last); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy got=%b exp=0", busy); end
    tick();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_burst_lock();
    set_data(2, 32'h20);
    drive(4'b0100, 1'b1, 4'b0100, 4'b0000);
    #1;
    tests_run++; if (src_ack !== 4'b0100) begin tests_failed++; $display("FAIL lock_ack0 got=%b exp=0100", src_ack); end
    tick();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL lock_busy got=%b exp=1", busy); end
    // Grant moves to requester 3, which has a ready single-beat packet.
    set_data(2, 32'h21);
    set_data(3, 32'h33);
    drive(4'b1000, 1'b1, 4'b1100, 4'b1000);
    #1;
    tests_run++; if (src_ack !== 4'b0100) begin tests_failed++; $display("FAIL lock_ack1 got=%b exp=0100", src_ack); end
    tests_run++; if (out_data !== 32'h20 || out_id !== 2'd2 || out_last !== 1'b0) begin tests_failed++; $display("FAIL lock_beat0 got=%h/%0d/%b exp=20/2/0", out_data, out_id, out_last); end
    tick();
    tests_run++; if (out_data !== 32'h21 || out_id !== 2'd2 || out_last !== 1'b0) begin tests_failed++; $display("FAIL lock_beat1 got=%h/%0d/%b exp=21/2/0", out_data, out_id, out_last); end
    set_data(2, 32'h22);
    src_last = 4'b1100;
    #1;
    tests_run++; if (src_ack !== 4'b0100) begin tests_failed++; $display("FAIL lock_ack2 got=%b exp=0100", src_ack); end
    tick();
    src_valid = 4'b1000;
    src_last  = 4'b1000;
    tests_run++; if (out_data !== 32'h22 || out_id !== 2'd2 || out_last !== 1'b1) begin tests_failed++; $display("FAIL lock_beat2 got=%h/%0d/%b exp=22/2/1", out_data, out_id, out_last); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL lock_busy_end got=%b exp=0", busy); end
    #1;
    tests_run++; if (src_ack !== 4'b1000) begin tests_failed++; $display("FAIL lock_ack_req3 got=%b exp=1000", src_ack); end
    tick();
    clear_inputs();
    tests_run++; if (out_data !== 32'h33 || out_id !== 2'd3 || out_last !== 1'b1) begin tests_failed++; $display("FAIL lock_req3 got=%h/%0d/%b exp=33/3/1", out_data, out_id, out_last); end
    tick();
  endtask

  task automatic test_backpressure();
    set_data(0, 32'h100);
    drive(4'b0001, 1'b1, 4'b0001, 4'b0000);
    tick();
    out_ready = 1'b0;
    set_data(0, 32'h101);
    for (int c = 0; c < 4; c++) begin
      #1;
      tests_run++; if (src_ack !== 4'b0000) begin tests_failed++; $display("FAIL bp_ack cyc=%0d got=%b exp=0000", c, src_ack); end
      tests_run++; if (out_valid !== 1'b1 || out_data !== 32'h100) begin tests_failed++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/100", c, out_valid, out_data); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests_run++; if (src_ack !== 4'b0001) begin tests_failed++; $display("FAIL bp_resume_ack got=%b exp=0001", src_ack); end
    tick();
    tests_run++; if (out_valid !== 1'b1 || out_data !== 32'h101) begin tests_failed++; $display("FAIL bp_resume1 got=%b/%h exp=1/101", out_valid, out_data); end
    set_data(0, 32'h102);
    src_last = 4'b0001;
    #1;
    tests_run++; if (src_ack !== 4'b0001) begin tests_failed++; $display("FAIL bp_resume_ack2 got=%b exp=0001", src_ack); end
    tick();
    clear_inputs();
    tests_run++; if (out_data !== 32'h102 || out_last !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL bp_resume2 got=%h/%b/%b exp=102/1/0", out_data, out_last, busy); end
    tick();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_owner_bubble();
    set_data(0, 32'h200);
    drive(4'b0001, 1'b1, 4'b0001, 4'b0000);
    tick();
    // Owner goes quiet while requester 2 is granted with a complete packet.
    set_data(2, 32'h2F);
    drive(4'b0100, 1'b1, 4'b0100, 4'b0100);
    for (int c = 0; c < 2; c++) begin
      #1;
      tests_run++; if (src_ack !== 4'b0000) begin tests_failed++; $display("FAIL bubble_ack cyc=%0d got=%b exp=0000", c, src_ack); end
      tick();
      tests_run++; if (out_valid !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL bubble_drain cyc=%0d got=%b/%b exp=0/1", c, out_valid, busy); end
    end
    set_data(0, 32'h201);
    drive(4'b0100, 1'b1, 4'b0101, 4'b0101);
    #1;
    tests_run++; if (src_ack !== 4'b0001) begin tests_failed++; $display("FAIL bubble_resume_ack got=%b exp=0001", src_ack); end
    tick();
    clear_inputs();
    tests_run++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 32'h201 || out_last !== 1'b1) begin tests_failed++; $display("FAIL bubble_resume got=%b/%0d/%h/%b exp=1/0/201/1", out_valid, out_id, out_data, out_last); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL bubble_busy got=%b exp=0", busy); end
    tick();
  endtask

  task automatic test_bad_grant();
    tests_run++; if (onehot_err !== 1'b0) begin tests_failed++; $display("FAIL bad_pre got=%b exp=0", onehot_err); end
    set_data(1, 32'h51);
    set_data(2, 32'h52);
    drive(4'b0110, 1'b1, 4'b0110, 4'b0110);
    #1;
    tests_run++; if (src_ack !== 4'b0010) begin tests_failed++; $display("FAIL bad_ack got=%b exp=0010", src_ack); end
    tick();
    clear_inputs();
    tests_run++; if (onehot_err !== 1'b1) begin tests_failed++; $display("FAIL bad_err got=%b exp=1", onehot_err); end
    tests_run++; if (out_id !== 2'd1 || out_data !== 32'h51) begin tests_failed++; $display("FAIL bad_beat got=%0d/%h exp=1/51", out_id, out_data); end
    tick();
    tick();
    tests_run++; if (onehot_err !== 1'b1) begin tests_failed++; $display("FAIL bad_sticky got=%b exp=1", onehot_err); end
  endtask

  task automatic test_reset_mid_burst();
    set_data(3, 32'h300);
    drive(4'b1000, 1'b1, 4'b1000, 4'b0000);
    tick();
    set_data(3, 32'h301);
    tick();
    tests_run++; if (out_data !== 32'h301 || busy !== 1'b1) begin tests_failed++; $display("FAIL rst_pre got=%h/%b exp=301/1", out_data, busy); end
    resetn = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_async got=%b/%b exp=0/0", out_valid, busy); end
    tests_run++; if (src_ack !== 4'b0000) begin tests_failed++; $display("FAIL rst_ack got=%b exp=0000", src_ack); end
    tests_run++; if (onehot_err !== 1'b0) begin tests_failed++; $display("FAIL rst_err got=%b exp=0", onehot_err); end
    tick();
    clear_inputs();
    resetn = 1'b1;
    tick();
    set_data(1, 32'h61);
    drive(4'b0010, 1'b1, 4'b0010, 4'b0010);
    #1;
    tests_run++; if (src_ack !== 4'b0010) begin tests_failed++; $display("FAIL rst_new_ack got=%b exp=0010", src_ack); end
    tick();
    clear_inputs();
    tests_run++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 32'h61 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_new_beat got=%b/%0d/%h/%b exp=1/1/61/0", out_valid, out_id, out_data, busy); end
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    resetn       = 1'b0;
    out_ready    = 1'b1;
    src_data     = '0;
    clear_inputs();
    #2;
    test_reset();
    test_single_beat();
    test_burst_lock();
    test_backpressure();
    test_owner_bubble();
    test_bad_grant();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
